// File: rtl/udp_tx_framer.sv
// UDP transmit framer: waits for the inter-frame gap, emits an 8-byte UDP header, then the payload.
// Optional build macro UDP_DYN_PORT_EN takes header ports from inputs latched at request time.
module udp_tx_framer #(
  parameter logic [15:0] P_SRC_PORT = 16'd8080,
  parameter logic [15:0] P_DST_PORT = 16'd8080,
  parameter logic [15:0] P_MAX_LEN  = 16'd1472
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_gap_ok,
  input  logic        i_send_req,
  input  logic [15:0] i_send_len,
`ifdef UDP_DYN_PORT_EN
  input  logic [15:0] i_src_port,
  input  logic [15:0] i_dst_port,
`endif
  output logic        o_busy,
  output logic        o_len_err,
  input  logic [7:0]  i_user_data,
  input  logic        i_user_valid,
  input  logic        i_user_last,
  output logic        o_user_ready,
  output logic [7:0]  o_ip_data,
  output logic        o_ip_valid,
  output logic        o_ip_last,
  output logic [15:0] o_ip_len,
  input  logic        i_ip_ready,
  output logic        o_frame_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_GAP, S_HEADER, S_PAYLOAD, S_PAD, S_DRAIN, S_TAIL
  } state_t;

  state_t      state;
  logic [15:0] len_reg;
  logic [15:0] cnt_reg;
  logic [2:0]  idx_reg;
  logic [15:0] src_port;
  logic [15:0] dst_port;
  logic [7:0]  hdr_byte;
  logic [15:0] cnt_inc;
  logic        load;
  logic        req_ok;

  assign load         = !o_ip_valid || i_ip_ready;
  assign cnt_inc      = cnt_reg + 16'd1;
  assign req_ok       = i_send_req && (i_send_len != 16'd0) && (i_send_len <= P_MAX_LEN);
  assign o_user_ready = ((state == S_PAYLOAD) && load) || (state == S_DRAIN);

`ifdef UDP_DYN_PORT_EN
  logic [15:0] src_port_reg;
  logic [15:0] dst_port_reg;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      src_port_reg <= 16'd0;
      dst_port_reg <= 16'd0;
    end else if (state == S_IDLE && req_ok) begin
      src_port_reg <= i_src_port;
      dst_port_reg <= i_dst_port;
    end
  end

  assign src_port = src_port_reg;
  assign dst_port = dst_port_reg;
`else
  assign src_port = P_SRC_PORT;
  assign dst_port = P_DST_PORT;
`endif

  // Checksum bytes (6, 7) are sent as zero, meaning "no checksum" for UDP over IPv4.
  always_comb begin
    hdr_byte = 8'h00;
    case (idx_reg)
      3'd0:    hdr_byte = src_port[15:8];
      3'd1:    hdr_byte = src_port[7:0];
      3'd2:    hdr_byte = dst_port[15:8];
      3'd3:    hdr_byte = dst_port[7:0];
      3'd4:    hdr_byte = o_ip_len[15:8];
      3'd5:    hdr_byte = o_ip_len[7:0];
      default: hdr_byte = 8'h00;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state        <= S_IDLE;
      len_reg      <= 16'd0;
      cnt_reg      <= 16'd0;
      idx_reg      <= 3'd0;
      o_busy       <= 1'b0;
      o_len_err    <= 1'b0;
      o_ip_data    <= 8'h00;
      o_ip_valid   <= 1'b0;
      o_ip_last    <= 1'b0;
      o_ip_len     <= 16'd0;
      o_frame_done <= 1'b0;
    end else begin
      o_len_err    <= 1'b0;
      o_frame_done <= o_ip_valid && i_ip_ready && o_ip_last;
      // A consumed output byte retires unless the state below loads a new one.
      if (load) begin
        o_ip_valid <= 1'b0;
        o_ip_last  <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (req_ok) begin
            len_reg  <= i_send_len;
            o_ip_len <= i_send_len + 16'd8;
            o_busy   <= 1'b1;
            idx_reg  <= 3'd0;
            cnt_reg  <= 16'd0;
            state    <= S_WAIT_GAP;
          end else if (i_send_req) begin
            o_len_err <= 1'b1;
          end
        end
        S_WAIT_GAP, S_HEADER: begin
          if ((state == S_HEADER || i_gap_ok) && load) begin
            o_ip_data  <= hdr_byte;
            o_ip_valid <= 1'b1;
            idx_reg    <= idx_reg + 3'd1;
            if (state == S_WAIT_GAP)
              state <= S_HEADER;
            else if (idx_reg == 3'd7)
              state <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (load && i_user_valid) begin
            o_ip_data  <= i_user_data;
            o_ip_valid <= 1'b1;
            o_ip_last  <= (cnt_inc == len_reg);
            cnt_reg    <= cnt_inc;
            if (cnt_inc == len_reg) begin
              if (i_user_last) begin
                state <= S_TAIL;
              end else begin
                o_len_err <= 1'b1;
                state     <= S_DRAIN;
              end
            end else if (i_user_last) begin
              o_len_err <= 1'b1;
              state     <= S_PAD;
            end
          end
        end
        S_PAD: begin
          if (load) begin
            o_ip_data  <= 8'h00;
            o_ip_valid <= 1'b1;
            o_ip_last  <= (cnt_inc == len_reg);
            cnt_reg    <= cnt_inc;
            if (cnt_inc == len_reg)
              state <= S_TAIL;
          end
        end
        S_DRAIN: begin
          // The final output byte may still be stalled downstream when the user stream ends.
          if (i_user_valid && i_user_last) begin
            if (load) begin
              o_busy <= 1'b0;
              state  <= S_IDLE;
            end else begin
              state <= S_TAIL;
            end
          end
        end
        S_TAIL: begin
          if (load) begin
            o_busy <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
